mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the fetch stage (IF) and the load/store stage (DM).
- Sits between PC/fetch logic and the data path on one side, and the memory macro on the other.
- Serialises accesses with a req/ready handshake, using round-robin arbitration on ties.
- Drives a stall to freeze PC and pipeline registers while an access is outstanding.

Parameters:
- ADDR_W, 16, byte address width for both requesters and the memory.
- LAT, 1, memory read latency in clock edges, legal range 1..15. LAT=1 means combinational-read memory.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  32  fetched instruction; registered, held until the next IF read completes.
- if_ready  out  1  one-cycle pulse: IF access complete.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_funct3  in  3  access size/sign (funct3), passed through to memory.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; registered, held until the next DM load completes.
- dm_ready  out  1  one-cycle pulse: DM access complete.
- mem_en  out  1  memory access strobe; one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_funct3  out  3  size/sign to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready); combinational.

Behaviour:

Reset (rst low, asynchronous, any state):
- state = IDLE; all registered outputs = 0; last_grant = IF.
- An in-flight transaction is abandoned: no ready pulse, no capture.

State machine IDLE / ACCESS / RESP:
- IDLE, no request: stay in IDLE, mem_en = 0.
- IDLE, on edge E0 with a request:
  - Grant the request and latch addr, we, wdata and funct3 into mem_* registers.
  - Record grant in owner.
  - Go to ACCESS with cnt = LAT-1.
  - mem_en = 1 for the first ACCESS cycle only. Memory performs a write at edge E0+1 when mem_we = 1.
- ACCESS: decrement cnt each edge. At the edge where cnt = 0 (edge E0+LAT):
  - Load: capture mem_rdata into if_rdata or dm_rdata according to owner.
  - Store: dm_rdata is unchanged.
  - Go to RESP.
- RESP: owner's ready = 1 for exactly one cycle; next edge goes to IDLE.
  - Requests are not sampled in RESP, so a requester can drop or replace its request after seeing ready.
- Timing:
  - ready is high in the cycle after edge E0+LAT.
  - One transaction occupies LAT+2 cycles; back-to-back throughput is one access per LAT+2 cycles.

Arbitration (sampled only in IDLE):
- Single request: grant it.
- Both requests: grant the one that is not last_grant. Since last_grant resets to IF, the first tie goes to DM; sustained ties alternate.
- last_grant updates on every grant.

Other rules:
- mem_addr, mem_we, mem_funct3 and mem_wdata hold their latched values through ACCESS and RESP, and remain unchanged in IDLE. Only mem_en qualifies an access.
- Non-owner inputs may change freely during a transaction without effect.
- A requester dropping req before ready is a protocol violation. The access still completes and the ready pulse is still issued.
- dm_we with IF owner is irrelevant: IF transactions always force mem_we = 0.
- cnt is 4 bits; with LAT=1, ACCESS lasts exactly one cycle.

Test Plan:
1. LAT=1. Reset; if_req=1, if_addr=0x0010, mem returns 0x00A00093 → mem_en high 1 cycle with mem_addr=0x0010; if_rdata=0x00A00093 and if_ready pulse 2 cycles after grant edge; stall high until the ready cycle.
2. LAT=3. dm_req store: dm_addr=0x0040, dm_wdata=0xDEADBEEF, funct3=3'b010 → mem_en=mem_we=1 for one cycle with those values; dm_ready in the cycle after edge E0+3; dm_rdata stays 0.
3. Both if_req and dm_req held from reset, LAT=1 → grant order DM, IF, DM, IF (4 transactions, 12 cycles); each ready pulses only for its owner.
4. Load 0x12345678 from dm_addr=0x0004 → dm_rdata=0x12345678 and held while a following IF read returns 0xFFFFFFFF into if_rdata only.
5. rst driven low mid-ACCESS (LAT=3, cnt=1) → immediately IDLE, mem_en=0, if_rdata/dm_rdata=0; no ready pulse after rst is released; a new request is serviced normally.
6. dm_req dropped during ACCESS → access completes, dm_ready still pulses once, FSM returns to IDLE, and a pending if_req is granted next.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port: fetch, load/store and memory sides.
// master = requesters + memory; slave = the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_funct3;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              stall;

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_funct3,
    output dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_funct3,
    input  mem_addr, mem_wdata,
    input  stall
  );

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_funct3,
    input  dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output mem_en, mem_we, mem_funct3,
    output mem_addr, mem_wdata,
    output stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between IF and DM.
// Ports: clk, rst (async active-low), bus (slave modport: IF/DM/mem/stall).
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LAT    = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state;
  state_t            nxt;
  logic [3:0]        cnt;
  logic              owner;
  logic              last_grant;
  logic              req_any;
  logic              pick_dm;
  logic              grant;
  logic              done;
  logic              en_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       dm_rdata_q;
  logic              if_rdy;
  logic              dm_rdy;

  // owner/last_grant: 1 = DM, 0 = IF.
  // On a tie the side that did not win last time gets the port.
  assign req_any = bus.if_req | bus.dm_req;
  assign pick_dm = bus.dm_req
                 & (~bus.if_req | ~last_grant);
  assign grant   = (state == IDLE) & req_any;
  assign done    = (state == ACCESS) & (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req_any) nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    if_rdy = 1'b0;
    dm_rdy = 1'b0;
    if (state == RESP) begin
      if_rdy = ~owner;
      dm_rdy = owner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      // Strobe lasts only the first ACCESS cycle.
      en_q <= grant;
      if (grant) begin
        owner      <= pick_dm;
        last_grant <= pick_dm;
        cnt        <= CNT_INIT;
        if (pick_dm) begin
          addr_q  <= bus.dm_addr;
          we_q    <= bus.dm_we;
          f3_q    <= bus.dm_funct3;
          wdata_q <= bus.dm_wdata;
        end else begin
          // Fetches are always full-word loads.
          addr_q  <= bus.if_addr;
          we_q    <= 1'b0;
          f3_q    <= 3'b010;
          wdata_q <= '0;
        end
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
      if (done && !we_q) begin
        if (owner) dm_rdata_q <= bus.mem_rdata;
        else       if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en     = en_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_funct3 = f3_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.if_ready   = if_rdy;
  assign bus.dm_ready   = dm_rdy;
  assign bus.stall      = (bus.if_req & ~if_rdy)
                        | (bus.dm_req & ~dm_rdy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=1 and LAT=3 instances,
// one word-indexed memory model per instance.
module tb_mem_port_arbiter;

  logic clk;
  logic rst1;
  logic rst3;
  int   checks;
  int   errors;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  mem_port_arbiter_if #(.ADDR_W(16)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(16)) b3 ();

  mem_port_arbiter #(.ADDR_W(16), .LAT(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1)
  );

  mem_port_arbiter #(.ADDR_W(16), .LAT(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign b1.mem_rdata = mem1[b1.mem_addr[9:2]];
  assign b3.mem_rdata = mem3[b3.mem_addr[9:2]];

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we)
      mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
    if (b3.mem_en && b3.mem_we)
      mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
  end

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [31:0] wd;
    logic        en;
    logic        we;
    logic [15:0] ma;
    logic        ifr;
    logic        dmr;
    logic        st;
    logic [31:0] ifd;
    logic [31:0] dmd;
  } vec_t;

  vec_t v [18];

  function automatic vec_t mk(
    input logic ir, input logic [15:0] ia,
    input logic dr, input logic dw,
    input logic [15:0] da, input logic [31:0] wd,
    input logic en, input logic we,
    input logic [15:0] ma,
    input logic ifr, input logic dmr, input logic st,
    input logic [31:0] ifd, input logic [31:0] dmd
  );
    vec_t r;
    r.ir = ir;   r.ia = ia;   r.dr = dr;
    r.dw = dw;   r.da = da;   r.wd = wd;
    r.en = en;   r.we = we;   r.ma = ma;
    r.ifr = ifr; r.dmr = dmr; r.st = st;
    r.ifd = ifd; r.dmd = dmd;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue a fetch on the LAT=3 instance; wait a bounded number of cycles.
  task automatic if_read3(input logic [15:0] a,
                          input logic [31:0] d,
                          input string nm);
    int n;
    b3.if_req  = 1'b1;
    b3.if_addr = a;
    n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while (!b3.if_ready && n < 10);
    chk({nm, "_lat"}, 32'(n), 32'd4);
    chk({nm, "_data"}, b3.if_rdata, d);
    b3.if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hFFFF_FFFF;
      mem3[i] = 32'hFFFF_FFFF;
    end
    mem1[1] = 32'h1234_5678;
    mem1[4] = 32'h00A0_0093;
    mem3[1] = 32'h1234_5678;

    v[0]  = mk(1,16'h10,0,0,16'h0,0,
               0,0,16'h0,0,0,1,0,0);
    v[1]  = mk(1,16'h10,0,0,16'h0,0,
               1,0,16'h10,0,0,1,0,0);
    v[2]  = mk(1,16'h10,0,0,16'h0,0,
               0,0,16'h10,1,0,0,32'h00A00093,0);
    v[3]  = mk(0,16'h0,0,0,16'h0,0,
               0,0,16'h10,0,0,0,32'h00A00093,0);
    v[4]  = mk(0,16'h0,1,0,16'h4,0,
               0,0,16'h10,0,0,1,32'h00A00093,0);
    v[5]  = mk(1,16'h20,1,0,16'h4,0,
               1,0,16'h4,0,0,1,32'h00A00093,0);
    v[6]  = mk(1,16'h20,1,0,16'h4,0,
               0,0,16'h4,0,1,1,32'h00A00093,32'h12345678);
    v[7]  = mk(1,16'h20,0,0,16'h0,0,
               0,0,16'h4,0,0,1,32'h00A00093,32'h12345678);
    v[8]  = mk(1,16'h20,0,0,16'h0,0,
               1,0,16'h20,0,0,1,32'h00A00093,32'h12345678);
    v[9]  = mk(1,16'h20,0,0,16'h0,0,
               0,0,16'h20,1,0,0,32'hFFFFFFFF,32'h12345678);
    v[10] = mk(0,16'h0,0,0,16'h0,0,
               0,0,16'h20,0,0,0,32'hFFFFFFFF,32'h12345678);
    v[11] = mk(1,16'h10,1,1,16'h8,32'hAB,
               0,0,16'h20,0,0,1,32'hFFFFFFFF,32'h12345678);
    v[12] = mk(1,16'h10,0,0,16'h0,0,
               1,1,16'h8,0,0,1,32'hFFFFFFFF,32'h12345678);
    v[13] = mk(1,16'h10,0,0,16'h0,0,
               0,1,16'h8,0,1,1,32'hFFFFFFFF,32'h12345678);
    v[14] = mk(1,16'h10,0,0,16'h0,0,
               0,1,16'h8,0,0,1,32'hFFFFFFFF,32'h12345678);
    v[15] = mk(1,16'h10,0,0,16'h0,0,
               1,0,16'h10,0,0,1,32'hFFFFFFFF,32'h12345678);
    v[16] = mk(1,16'h10,0,0,16'h0,0,
               0,0,16'h10,1,0,0,32'h00A00093,32'h12345678);
    v[17] = mk(0,16'h0,0,0,16'h0,0,
               0,0,16'h10,0,0,0,32'h00A00093,32'h12345678);

    rst1 = 1'b0;
    rst3 = 1'b0;
    b1.if_req = 0; b1.if_addr = 0;
    b1.dm_req = 0; b1.dm_we = 0;
    b1.dm_funct3 = 3'b010;
    b1.dm_addr = 0; b1.dm_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0;
    b3.dm_req = 0; b3.dm_we = 0;
    b3.dm_funct3 = 0;
    b3.dm_addr = 0; b3.dm_wdata = 0;

    #3;
    chk("rst_mem_en", 32'(b1.mem_en), 0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 0);
    chk("rst_if_rdata", b1.if_rdata, 0);
    chk("rst_dm_rdata", b1.dm_rdata, 0);
    chk("rst_ready", {b1.if_ready, b1.dm_ready}, 0);
    chk("rst_stall", 32'(b1.stall), 0);

    @(posedge clk); #1;
    rst1 = 1'b1;
    rst3 = 1'b1;

    // LAT=1 cycle table: single fetch, load then fetch, store with drop.
    for (int i = 0; i < 18; i++) begin
      b1.if_req   = v[i].ir;
      b1.if_addr  = v[i].ia;
      b1.dm_req   = v[i].dr;
      b1.dm_we    = v[i].dw;
      b1.dm_addr  = v[i].da;
      b1.dm_wdata = v[i].wd;
      #2;
      chk($sformatf("v%0d_en", i), 32'(b1.mem_en), 32'(v[i].en));
      chk($sformatf("v%0d_we", i), 32'(b1.mem_we), 32'(v[i].we));
      chk($sformatf("v%0d_addr", i), 32'(b1.mem_addr), 32'(v[i].ma));
      chk($sformatf("v%0d_ifr", i), 32'(b1.if_ready), 32'(v[i].ifr));
      chk($sformatf("v%0d_dmr", i), 32'(b1.dm_ready), 32'(v[i].dmr));
      chk($sformatf("v%0d_stall", i), 32'(b1.stall), 32'(v[i].st));
      chk($sformatf("v%0d_ifd", i), b1.if_rdata, v[i].ifd);
      chk($sformatf("v%0d_dmd", i), b1.dm_rdata, v[i].dmd);
      @(posedge clk); #1;
    end
    chk("store_mem", mem1[2], 32'hAB);

    // Sustained tie from reset: DM, IF, DM, IF.
    rst1 = 1'b0;
    b1.if_req = 1; b1.if_addr = 16'h10;
    b1.dm_req = 1; b1.dm_we = 0;
    b1.dm_addr = 16'h4;
    #2;
    chk("tie_rst_en", 32'(b1.mem_en), 0);
    chk("tie_rst_ifd", b1.if_rdata, 0);
    chk("tie_rst_stall", 32'(b1.stall), 1);
    @(posedge clk); #1;
    rst1 = 1'b1;
    #2;
    chk("tie_c0_rdy", {b1.if_ready, b1.dm_ready}, 0);
    for (int c = 1; c < 12; c++) begin
      @(posedge clk); #3;
      chk($sformatf("tie_c%0d_ifr", c), 32'(b1.if_ready),
          32'(c == 5 || c == 11));
      chk($sformatf("tie_c%0d_dmr", c), 32'(b1.dm_ready),
          32'(c == 2 || c == 8));
      chk($sformatf("tie_c%0d_en", c), 32'(b1.mem_en),
          32'(c % 3 == 1));
      chk($sformatf("tie_c%0d_stall", c), 32'(b1.stall), 1);
      if (c % 3 == 1)
        chk($sformatf("tie_c%0d_addr", c), 32'(b1.mem_addr),
            (c == 1 || c == 7) ? 32'h4 : 32'h10);
    end
    b1.if_req = 0;
    b1.dm_req = 0;

    // LAT=3 store.
    b3.dm_req = 1; b3.dm_we = 1;
    b3.dm_funct3 = 3'b010;
    b3.dm_addr = 16'h40;
    b3.dm_wdata = 32'hDEADBEEF;
    #2;
    chk("st3_r0_stall", 32'(b3.stall), 1);
    chk("st3_r0_en", 32'(b3.mem_en), 0);
    for (int r = 1; r < 6; r++) begin
      @(posedge clk); #3;
      chk($sformatf("st3_r%0d_en", r), 32'(b3.mem_en),
          32'(r == 1));
      chk($sformatf("st3_r%0d_dmr", r), 32'(b3.dm_ready),
          32'(r == 4));
      if (r == 1) begin
        chk("st3_we", 32'(b3.mem_we), 1);
        chk("st3_addr", 32'(b3.mem_addr), 32'h40);
        chk("st3_wdata", b3.mem_wdata, 32'hDEADBEEF);
        chk("st3_f3", 32'(b3.mem_funct3), 32'h2);
      end
      if (r == 4) begin
        chk("st3_dmd", b3.dm_rdata, 0);
        chk("st3_stall", 32'(b3.stall), 0);
        b3.dm_req = 0;
        b3.dm_we = 0;
      end
    end
    chk("st3_mem", mem3[16], 32'hDEADBEEF);

    // LAT=3 fetch, then a fetch cut short by reset.
    if_read3(16'h40, 32'hDEADBEEF, "rd3a");
    @(posedge clk); #1;
    b3.if_req = 1; b3.if_addr = 16'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_en", 32'(b3.mem_en), 0);
    chk("mid_rdy", 32'(b3.if_ready), 0);
    rst3 = 1'b0;
    #1;
    chk("ar_ifd", b3.if_rdata, 0);
    chk("ar_dmd", b3.dm_rdata, 0);
    chk("ar_addr", 32'(b3.mem_addr), 0);
    chk("ar_en", 32'(b3.mem_en), 0);
    b3.if_req = 0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    for (int r = 0; r < 5; r++) begin
      @(posedge clk); #3;
      chk($sformatf("post_rst%0d_rdy", r),
          {b3.if_ready, b3.dm_ready, b3.mem_en}, 0);
    end
    if_read3(16'h4, 32'h12345678, "rd3b");
    chk("rd3b_dmd", b3.dm_rdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
